// File: rtl/spi_register_responder.sv
// SPI mode-0 register responder: one address byte in per CS-low frame, then the addressed
// register file bytes (auto-incrementing, wrapping) are shifted out MSB first on MISO.
module spi_register_responder #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS_n,
    output logic              o_SPI_MISO,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [7:0]        reg_wr_data,
    output logic [7:0]        addr_byte,
    output logic              addr_valid,
    output logic [7:0]        resp_count,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    logic [2:0] pins_raw;
    logic [2:0] pins_s;
    logic       sclk_s, mosi_s, cs_n_s;
    logic       sclk_prev_q, cs_n_prev_q;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t              state_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          tx_q;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                miso_q;
    logic [7:0]          addr_byte_q;
    logic                addr_valid_q;
    logic [7:0]          resp_count_q;
    logic                busy_q;
    logic [7:0]          regs_q [DEPTH];

    assign pins_raw = {i_SPI_CS_n, i_SPI_MOSI, i_SPI_Clk};

    // CS synchronizer flops reset low so a frame already in progress at reset release
    // never produces a falling edge; only a genuine high-to-low transition starts a frame.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign pins_s = pins_raw;
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
                end else begin
                    sync_q[0] <= pins_raw;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign pins_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign sclk_s = pins_s[0];
    assign mosi_s = pins_s[1];
    assign cs_n_s = pins_s[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_n_prev_q <= cs_n_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_n_s & cs_n_prev_q;
    assign cs_rise   = cs_n_s & ~cs_n_prev_q;

    assign rx_d     = {rx_q[6:0], mosi_s};
    assign rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
        end else if (reg_wr_en) begin
            regs_q[reg_wr_addr] <= reg_wr_data;
        end
    end

    // tx_q loads read the register array with non-blocking semantics, so a write to the
    // same address in the load cycle leaves the old byte in the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 8'h00;
            tx_q         <= 8'h00;
            rd_ptr_q     <= '0;
            miso_q       <= 1'b0;
            addr_byte_q  <= 8'h00;
            addr_valid_q <= 1'b0;
            resp_count_q <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            addr_valid_q <= 1'b0;
            if (cs_rise) begin
                state_q   <= IDLE;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cs_fall) begin
                            state_q      <= ADDR;
                            bit_cnt_q    <= 3'd0;
                            rx_q         <= 8'h00;
                            miso_q       <= 1'b0;
                            busy_q       <= 1'b1;
                            resp_count_q <= 8'h00;
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                addr_byte_q  <= rx_d;
                                addr_valid_q <= 1'b1;
                                rd_ptr_q     <= rx_d[ADDR_W-1:0];
                                tx_q         <= regs_q[rx_d[ADDR_W-1:0]];
                                state_q      <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                resp_count_q <= resp_count_q + 8'd1;
                                rd_ptr_q     <= rd_ptr_d;
                                tx_q         <= regs_q[rd_ptr_d];
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_SPI_MISO = miso_q;
    assign addr_byte  = addr_byte_q;
    assign addr_valid = addr_valid_q;
    assign resp_count = resp_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_register_responder.sv
// Directed bench: a mode-0 SPI master model drives frames and checks the bytes read back.
module tb_spi_register_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, mosi, cs_n;
    logic       miso;
    logic       reg_wr_en;
    logic [2:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] addr_byte;
    logic       addr_valid;
    logic [7:0] resp_count;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int av_cnt = 0;
    int av0;
    logic [7:0] r0, r1, r2;

    spi_register_responder #(.ADDR_W(3), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_SPI_Clk  (sclk),
        .i_SPI_MOSI (mosi),
        .i_SPI_CS_n (cs_n),
        .o_SPI_MISO (miso),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .addr_byte  (addr_byte),
        .addr_valid (addr_valid),
        .resp_count (resp_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (addr_valid === 1'b1) av_cnt <= av_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Sends the top nbits of tx; with wr_flag, writes reg2=0x77 in the cycle the
    // address byte completes (third clk edge after the 8th SCLK rise is driven).
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit wr_flag,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            rx[i] = miso;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (wr_flag && i == 0 && k == 2) begin
                    reg_wr_en = 1'b1; reg_wr_addr = 3'd2; reg_wr_data = 8'h77;
                end
                if (wr_flag && i == 0 && k == 3) begin
                    reg_wr_en = 1'b0;
                    chk("collide_addr_valid", {31'd0, addr_valid}, 32'd1);
                end
            end
            sclk = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        reg_wr_en = 1'b0; reg_wr_addr = 3'd0; reg_wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr_byte", {24'd0, addr_byte}, 32'd0);
        chk("rst_addr_valid", {31'd0, addr_valid}, 32'd0);
        chk("rst_resp_count", {24'd0, resp_count}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // 1: basic two-byte read of reg3
        wr_reg(3'd3, 8'hA5);
        wr_reg(3'd4, 8'h3C);
        av0 = av_cnt;
        cs_low();
        chk("t1_busy_in_frame", {31'd0, busy}, 32'd1);
        xfer(8'h03, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        cs_high();
        chk("t1_rx0", {24'd0, r0}, 32'h00);
        chk("t1_rx1", {24'd0, r1}, 32'hA5);
        chk("t1_addr_byte", {24'd0, addr_byte}, 32'h03);
        chk("t1_av_pulses", av_cnt - av0, 32'd1);
        chk("t1_resp_count", {24'd0, resp_count}, 32'd1);
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        chk("t1_miso_after", {31'd0, miso}, 32'd0);

        // 2: pointer wrap 7 -> 0
        wr_reg(3'd7, 8'h11);
        wr_reg(3'd0, 8'h22);
        cs_low();
        xfer(8'h07, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        xfer(8'h00, 8, 1'b0, r2);
        cs_high();
        chk("t2_rx0", {24'd0, r0}, 32'h00);
        chk("t2_rx1", {24'd0, r1}, 32'h11);
        chk("t2_rx2", {24'd0, r2}, 32'h22);
        chk("t2_resp_count", {24'd0, resp_count}, 32'd2);

        // 3: upper address bits ignored for lookup, reported in addr_byte
        wr_reg(3'd1, 8'h5A);
        cs_low();
        xfer(8'hF9, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        cs_high();
        chk("t3_rx1", {24'd0, r1}, 32'h5A);
        chk("t3_addr_byte", {24'd0, addr_byte}, 32'hF9);

        // 4: aborted address byte
        av0 = av_cnt;
        cs_low();
        xfer(8'h02, 5, 1'b0, r0);
        cs_high();
        chk("t4_no_av", av_cnt - av0, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_miso", {31'd0, miso}, 32'd0);
        chk("t4_addr_hold", {24'd0, addr_byte}, 32'hF9);
        wr_reg(3'd2, 8'h10);
        cs_low();
        xfer(8'h02, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        cs_high();
        chk("t4_rx1", {24'd0, r1}, 32'h10);

        // 5: write to the addressed register in the load cycle returns the old value
        cs_low();
        xfer(8'h02, 8, 1'b1, r0);
        xfer(8'h00, 8, 1'b0, r1);
        cs_high();
        chk("t5_old_value", {24'd0, r1}, 32'h10);
        cs_low();
        xfer(8'h02, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        cs_high();
        chk("t5_new_value", {24'd0, r1}, 32'h77);

        // 6: reset mid data byte, then stray frame and SCLK with CS high
        cs_low();
        xfer(8'h03, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        chk("t6_rx1", {24'd0, r1}, 32'hA5);
        xfer(8'h00, 4, 1'b0, r2);
        chk("t6_resp_pre", {24'd0, resp_count}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_miso", {31'd0, miso}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_addr", {24'd0, addr_byte}, 32'd0);
        chk("t6_rst_resp", {24'd0, resp_count}, 32'd0);
        chk("t6_rst_av", {31'd0, addr_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        av0 = av_cnt;
        xfer(8'h03, 8, 1'b0, r0);
        chk("t6_stray_busy", {31'd0, busy}, 32'd0);
        chk("t6_stray_av", av_cnt - av0, 32'd0);
        chk("t6_stray_addr", {24'd0, addr_byte}, 32'd0);
        cs_high();
        for (int j = 0; j < 8; j++) begin
            mosi = j[0];
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        chk("t6_csh_busy", {31'd0, busy}, 32'd0);
        chk("t6_csh_av", av_cnt - av0, 32'd0);
        chk("t6_csh_miso", {31'd0, miso}, 32'd0);
        chk("t6_csh_resp", {24'd0, resp_count}, 32'd0);
        cs_low();
        xfer(8'h03, 8, 1'b0, r0);
        xfer(8'h00, 8, 1'b0, r1);
        cs_high();
        chk("t6_regs_cleared", {24'd0, r1}, 32'h00);
        chk("t6_addr_after", {24'd0, addr_byte}, 32'h03);
        chk("t6_av_after", av_cnt - av0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
